// File: rtl/axis_if_if.sv
// AXI-Stream bundle shared by the arbitrating mux and its neighbours.
// Sideband fields are dropped entirely in the light-stream build.
interface axis_if #(
   parameter int DATA_WIDTH = 32
`ifndef USE_LIGHT_STREAM
   ,
   parameter int ID_WIDTH   = 4,
   parameter int DEST_WIDTH = 4,
   parameter int USER_WIDTH = 4
`endif
);
   logic                    TVALID;
   logic                    TREADY;
   logic [DATA_WIDTH-1:0]   TDATA;
`ifndef USE_LIGHT_STREAM
   logic [DATA_WIDTH/8-1:0] TSTRB;
   logic [DATA_WIDTH/8-1:0] TKEEP;
   logic                    TLAST;
   logic [ID_WIDTH-1:0]     TID;
   logic [DEST_WIDTH-1:0]   TDEST;
   logic [USER_WIDTH-1:0]   TUSER;

   modport m (output TVALID, TDATA, TSTRB, TKEEP, TLAST, TID, TDEST, TUSER,
              input  TREADY);
   modport s (input  TVALID, TDATA, TSTRB, TKEEP, TLAST, TID, TDEST, TUSER,
              output TREADY);
`else
   modport m (output TVALID, TDATA, input  TREADY);
   modport s (input  TVALID, TDATA, output TREADY);
`endif
endinterface

// File: rtl/axis_if_arb_mux.sv
// N-to-1 AXI-Stream packet mux with round-robin arbitration.
// A grant is held until the TLAST beat is accepted, so packets never
// interleave; a 2-entry skid buffer registers everything on the sink side.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | no grant, every source sees TREADY=0
//   S_LOCKED | in[grant_idx] feeds the skid buffer until its TLAST beat
module axis_if_arb_mux #(
   parameter int CHANNEL_NUMBER       = 5,
   parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER),
   parameter int DATA_WIDTH           = 32
`ifndef USE_LIGHT_STREAM
   ,
   parameter int ID_WIDTH             = 4,
   parameter int DEST_WIDTH           = 4,
   parameter int USER_WIDTH           = 4
`endif
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            en,
   axis_if.s                               in [0:CHANNEL_NUMBER-1],
   axis_if.m                               out,
   output logic                            grant_valid,
   output logic [CHANNEL_NUMBER_WIDTH-1:0] grant_idx
);

   localparam int CW = CHANNEL_NUMBER_WIDTH;
`ifdef USE_LIGHT_STREAM
   localparam int PW = DATA_WIDTH;
`else
   localparam int KW       = DATA_WIDTH / 8;
   localparam int LAST_POS = ID_WIDTH + DEST_WIDTH + USER_WIDTH;
   localparam int PW       = DATA_WIDTH + 2 * KW + 1 + LAST_POS;
`endif

   typedef enum logic [0:0] {S_IDLE, S_LOCKED} state_t;

   state_t                    state_q, state_d;
   logic [CW-1:0]             gidx_q, gidx_d;
   logic [CW-1:0]             rr_q, rr_d;
   logic                      gval_q, gval_d;
   logic [1:0]                cnt_q, cnt_d;
   logic [PW-1:0]             head_q, head_d;
   logic [PW-1:0]             tail_q, tail_d;
   logic                      ovld_q, ovld_d;

   logic [CHANNEL_NUMBER-1:0] src_vld;
   logic [PW-1:0]             src_pay [CHANNEL_NUMBER];
   logic [PW-1:0]             sel_pay;
   logic                      sel_last;
   logic                      src_rdy;
   logic                      push;
   logic                      pop;
   logic [CW-1:0]             winner;
   logic                      found;
   logic [CW:0]               cand;

   // Flatten the interface array so the granted source can be picked by index.
   for (genvar i = 0; i < CHANNEL_NUMBER; i++) begin : g_src
      assign src_vld[i] = in[i].TVALID;
`ifdef USE_LIGHT_STREAM
      assign src_pay[i] = in[i].TDATA;
`else
      assign src_pay[i] = {in[i].TDATA, in[i].TSTRB, in[i].TKEEP, in[i].TLAST,
                           in[i].TID, in[i].TDEST, in[i].TUSER};
`endif
      assign in[i].TREADY = src_rdy && (gidx_q == CW'(i));
   end

   // Ready depends only on registered state and occupancy, never on out.TREADY.
   assign src_rdy = (state_q == S_LOCKED) && (cnt_q != 2'd2);
   assign sel_pay = src_pay[gidx_q];
   assign push    = src_rdy && src_vld[gidx_q];
   assign pop     = ovld_q && out.TREADY;
`ifdef USE_LIGHT_STREAM
   assign sel_last = 1'b1;
`else
   assign sel_last = sel_pay[LAST_POS];
`endif

   // Round-robin search: first requester at or after rr_q, wrapping.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      cand   = '0;
      for (int k = 0; k < CHANNEL_NUMBER; k++) begin
         cand = {1'b0, rr_q} + (CW+1)'(k);
         if (cand >= (CW+1)'(CHANNEL_NUMBER)) cand = cand - (CW+1)'(CHANNEL_NUMBER);
         if (!found && src_vld[cand[CW-1:0]]) begin
            found  = 1'b1;
            winner = cand[CW-1:0];
         end
      end
   end

   // Grant FSM next state: lock on any request while enabled, release on TLAST.
   always_comb begin
      state_d = state_q;
      gidx_d  = gidx_q;
      gval_d  = gval_q;
      rr_d    = rr_q;
      case (state_q)
         S_IDLE: begin
            if (en && found) begin
               state_d = S_LOCKED;
               gidx_d  = winner;
               gval_d  = 1'b1;
            end
         end
         S_LOCKED: begin
            if (push && sel_last) begin
               state_d = S_IDLE;
               gval_d  = 1'b0;
               rr_d    = (gidx_q == CW'(CHANNEL_NUMBER - 1)) ? '0 : gidx_q + CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Grant FSM registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         gidx_q  <= '0;
         gval_q  <= 1'b0;
         rr_q    <= '0;
      end else begin
         state_q <= state_d;
         gidx_q  <= gidx_d;
         gval_q  <= gval_d;
         rr_q    <= rr_d;
      end
   end

   // Skid buffer: head is always what the sink sees, tail only fills on a stall.
   always_comb begin
      cnt_d  = cnt_q;
      head_d = head_q;
      tail_d = tail_q;
      case ({push, pop})
         2'b10: begin
            if (cnt_q == 2'd0) head_d = sel_pay;
            else               tail_d = sel_pay;
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            if (cnt_q == 2'd2) head_d = tail_q;
            cnt_d = cnt_q - 2'd1;
         end
         2'b11: begin
            if (cnt_q == 2'd1) begin
               head_d = sel_pay;
            end else begin
               head_d = tail_q;
               tail_d = sel_pay;
            end
         end
         default: ;
      endcase
      ovld_d = (cnt_d != 2'd0);
   end

   // Skid buffer registers; reset flushes any partial packet.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= 2'd0;
         head_q <= '0;
         tail_q <= '0;
         ovld_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         head_q <= head_d;
         tail_q <= tail_d;
         ovld_q <= ovld_d;
      end
   end

   assign out.TVALID  = ovld_q;
`ifdef USE_LIGHT_STREAM
   assign out.TDATA   = head_q;
`else
   assign {out.TDATA, out.TSTRB, out.TKEEP, out.TLAST,
           out.TID, out.TDEST, out.TUSER} = head_q;
`endif
   assign grant_valid = gval_q;
   assign grant_idx   = gidx_q;

endmodule

// File: tb/tb_axis_if_arb_mux.sv
// Directed bench for the round-robin packet mux.
`timescale 1ns/1ps
module tb_axis_if_arb_mux;
   localparam int N = 5;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       grant_valid;
   logic [2:0] grant_idx;

   always #5 clk = ~clk;

   axis_if src [0:N-1] ();
   axis_if sink ();

   axis_if_arb_mux dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .in          (src),
      .out         (sink),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   // Per-source beat memories; each source streams its memory in order.
   logic [31:0]  sdat  [N][64];
   logic         slst  [N][64];
   int           slen  [N];
   int           spos  [N] = '{default: 0};
   logic         shold [N];
   logic [N-1:0] src_vld;
   logic [N-1:0] src_rdy;

   for (genvar i = 0; i < N; i++) begin : g_src
      assign src[i].TVALID = !shold[i] && (spos[i] < slen[i]);
      assign src[i].TDATA  = sdat[i][spos[i][5:0]];
      assign src[i].TLAST  = slst[i][spos[i][5:0]];
      assign src[i].TSTRB  = 4'hF;
      assign src[i].TKEEP  = 4'hF;
      assign src[i].TID    = 4'(i);
      assign src[i].TDEST  = 4'(N - 1 - i);
      assign src[i].TUSER  = 4'(i + 8);
      assign src_vld[i]    = src[i].TVALID;
      assign src_rdy[i]    = src[i].TREADY;
   end

   // Monitor: source advance, sink beat log, grant log, occupancy model.
   logic [31:0] rec_dat [256];
   logic        rec_lst [256];
   logic [3:0]  rec_id  [256];
   int          rec_cyc [256];
   int          rec_n   = 0;
   int          glog    [64];
   int          gn      = 0;
   logic        gv_prev = 1'b0;
   int          cyc     = 0;
   int          occ_m   = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < N; i++)
         if (src_vld[i] && src_rdy[i]) spos[i] <= spos[i] + 1;
      if (sink.TVALID && sink.TREADY) begin
         rec_dat[rec_n] <= sink.TDATA;
         rec_lst[rec_n] <= sink.TLAST;
         rec_id[rec_n]  <= sink.TID;
         rec_cyc[rec_n] <= cyc;
         rec_n          <= rec_n + 1;
      end
      if (rst) begin
         gv_prev <= 1'b0;
         occ_m   <= 0;
      end else begin
         gv_prev <= grant_valid;
         if (grant_valid && !gv_prev) begin
            glog[gn] <= int'(grant_idx);
            gn       <= gn + 1;
         end
         occ_m <= occ_m + ((|(src_vld & src_rdy)) ? 1 : 0)
                        - ((sink.TVALID && sink.TREADY) ? 1 : 0);
      end
   end

   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic add_pkt(input int s, input logic [31:0] base, input int n);
      for (int k = 0; k < n; k++) begin
         sdat[s][slen[s] + k] = base + 32'(k);
         slst[s][slen[s] + k] = (k == n - 1);
      end
      slen[s] = slen[s] + n;
   endtask

   task automatic wait_rec(input int target, input int budget);
      int t;
      t = 0;
      while (rec_n < target && t < budget) begin
         @(negedge clk);
         t++;
      end
      chk("beat_count", rec_n, target);
   endtask

   int         b;
   int         g;
   int         t;
   int         bad;
   int         full_seen;
   logic [4:0] rdy_acc;

   initial begin
      rst         = 1'b1;
      en          = 1'b0;
      sink.TREADY = 1'b0;
      for (int i = 0; i < N; i++) begin
         shold[i] = 1'b1;
         slen[i]  = 0;
      end

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_tvalid", sink.TVALID, 0);
      chk("rst_tdata", sink.TDATA, 0);
      chk("rst_tlast", sink.TLAST, 0);
      chk("rst_grant_valid", grant_valid, 0);
      chk("rst_grant_idx", grant_idx, 0);
      chk("rst_src_ready", src_rdy, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      en          = 1'b1;
      sink.TREADY = 1'b1;
      for (int i = 0; i < N; i++) shold[i] = 1'b0;

      // Single source on in[2]
      b = rec_n; g = gn; rdy_acc = '0;
      add_pkt(2, 32'hA0, 4);
      t = 0;
      while (rec_n < b + 4 && t < 40) begin
         @(negedge clk);
         rdy_acc |= src_rdy;
         t++;
      end
      chk("t1_count", rec_n, b + 4);
      for (int k = 0; k < 4; k++) chk("t1_data", rec_dat[b + k], 32'hA0 + 32'(k));
      chk("t1_last_mid", rec_lst[b + 2], 0);
      chk("t1_last_end", rec_lst[b + 3], 1);
      chk("t1_back_to_back", rec_cyc[b + 3] - rec_cyc[b], 3);
      chk("t1_grant", glog[g], 2);
      chk("t1_tid", rec_id[b], 2);
      chk("t1_ready_mask", rdy_acc, 5'b00100);

      // Round robin from a fresh pointer, two 2-beat packets per source
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      b = rec_n; g = gn;
      for (int s = 0; s < N; s++)
         for (int p = 0; p < 2; p++)
            add_pkt(s, 32'h100 * 32'(s + 1) + 32'h10 * 32'(p), 2);
      wait_rec(b + 20, 100);
      for (int k = 0; k < 6; k++) chk("t2_grant_order", glog[g + k], k % 5);
      for (int k = 0; k < 10; k++)
         for (int j = 0; j < 2; j++)
            chk("t2_data", rec_dat[b + 2 * k + j],
                32'h100 * 32'(k % 5 + 1) + 32'h10 * 32'(k / 5) + 32'(j));
      for (int k = 0; k < 9; k++)
         chk("t2_pkt_spacing", rec_cyc[b + 2 * k + 2] - rec_cyc[b + 2 * k], 3);

      // Sink backpressure 1010... on an 8-beat packet from in[1]
      b = rec_n; bad = 0; full_seen = 0;
      add_pkt(1, 32'hB0, 8);
      t = 0;
      while (rec_n < b + 8 && t < 80) begin
         @(posedge clk);
         #1 sink.TREADY = ~sink.TREADY;
         @(negedge clk);
         if (src_rdy !== ((grant_valid && occ_m < 2) ? 5'b00010 : 5'b00000)) bad++;
         if (grant_valid && occ_m == 2) full_seen++;
         t++;
      end
      @(posedge clk);
      #1 sink.TREADY = 1'b1;
      repeat (4) @(negedge clk);
      chk("t3_count_exact", rec_n, b + 8);
      for (int k = 0; k < 8; k++) chk("t3_data", rec_dat[b + k], 32'hB0 + 32'(k));
      chk("t3_last_mid", rec_lst[b + 6], 0);
      chk("t3_last_end", rec_lst[b + 7], 1);
      chk("t3_ready_rule", bad, 0);
      chk("t3_full_reached", full_seen > 0, 1);

      // en gating: no grant while en=0
      @(posedge clk);
      #1 en = 1'b0;
      b = rec_n; g = gn;
      add_pkt(1, 32'hC0, 2);
      repeat (6) @(negedge clk);
      chk("t4_no_grant", grant_valid, 0);
      chk("t4_no_ready", src_rdy, 0);
      chk("t4_no_beats", rec_n, b);
      @(posedge clk);
      #1 en = 1'b1;
      wait_rec(b + 2, 20);
      chk("t4_grant_c", glog[g], 1);
      chk("t4_data_c0", rec_dat[b], 32'hC0);
      chk("t4_data_c1", rec_dat[b + 1], 32'hC1);

      // en dropped mid-packet: packet finishes, next grant waits for en
      b = rec_n; g = gn;
      add_pkt(4, 32'hD0, 4);
      t = 0;
      while (!grant_valid && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("t4_grant_d_valid", grant_valid, 1);
      @(posedge clk);
      #1 en = 1'b0;
      add_pkt(0, 32'hE0, 2);
      wait_rec(b + 4, 30);
      repeat (6) @(negedge clk);
      chk("t4_held_off", grant_valid, 0);
      chk("t4_grant_count", gn, g + 1);
      chk("t4_grant_d", glog[g], 4);
      for (int k = 0; k < 4; k++) chk("t4_data_d", rec_dat[b + k], 32'hD0 + 32'(k));
      chk("t4_last_d", rec_lst[b + 3], 1);
      @(posedge clk);
      #1 en = 1'b1;
      wait_rec(b + 6, 20);
      chk("t4_grant_e", glog[g + 1], 0);
      chk("t4_data_e0", rec_dat[b + 4], 32'hE0);
      chk("t4_data_e1", rec_dat[b + 5], 32'hE1);

      // Pointer wrap: single beat from in[3] leaves rr_ptr=4
      b = rec_n; g = gn;
      add_pkt(3, 32'h50, 1);
      wait_rec(b + 1, 20);
      chk("t5_grant_h", glog[g], 3);
      chk("t5_data_h", rec_dat[b], 32'h50);
      b = rec_n; g = gn;
      add_pkt(0, 32'hF0, 2);
      add_pkt(0, 32'hF2, 2);
      add_pkt(3, 32'h60, 2);
      wait_rec(b + 6, 40);
      chk("t5_wrap_first", glog[g], 0);
      chk("t5_wrap_second", glog[g + 1], 3);
      chk("t5_wrap_third", glog[g + 2], 0);
      chk("t5_data0", rec_dat[b], 32'hF0);
      chk("t5_data1", rec_dat[b + 1], 32'hF1);
      chk("t5_data2", rec_dat[b + 2], 32'h60);
      chk("t5_data3", rec_dat[b + 3], 32'h61);
      chk("t5_data4", rec_dat[b + 4], 32'hF2);
      chk("t5_data5", rec_dat[b + 5], 32'hF3);

      // Reset mid-packet
      b = rec_n;
      add_pkt(2, 32'h70, 5);
      wait_rec(b + 2, 20);
      #1 rst = 1'b1;
      #1;
      chk("t6_tvalid_drop", sink.TVALID, 0);
      chk("t6_grant_drop", grant_valid, 0);
      chk("t6_ready_drop", src_rdy, 0);
      chk("t6_tdata_zero", sink.TDATA, 0);
      shold[2] = 1'b1;
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
      b = rec_n; g = gn;
      add_pkt(3, 32'h80, 3);
      wait_rec(b + 3, 20);
      chk("t6_grant", glog[g], 3);
      for (int k = 0; k < 3; k++) chk("t6_data", rec_dat[b + k], 32'h80 + 32'(k));
      chk("t6_last", rec_lst[b + 2], 1);
      repeat (3) @(negedge clk);
      chk("t6_no_leftover", rec_n, b + 3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/axis_if_arb_mux.md
# axis_if_arb_mux

Packet-level AXI-Stream N-to-1 arbitrating multiplexer, the gather-side counterpart of the AXI-Stream channel demultiplexer. It merges `CHANNEL_NUMBER` source streams onto one sink stream with round-robin arbitration. Once a source is granted, the grant is held until the beat carrying TLAST is accepted, so packets never interleave. A 2-entry output skid buffer registers all sink-side signals and sustains one beat per cycle.

## Interface
- `CHANNEL_NUMBER`, 5: number of source streams (≥2).
- `CHANNEL_NUMBER_WIDTH`, `$clog2(CHANNEL_NUMBER)`: width of the grant index.
- `DATA_WIDTH`, 32: TDATA width; TSTRB/TKEEP are `DATA_WIDTH/8`.
- `ID_WIDTH`, 4; `DEST_WIDTH`, 4; `USER_WIDTH`, 4: sideband widths. These parameters and the TSTRB/TKEEP/TLAST/TID/TDEST/TUSER signals are absent when `USE_LIGHT_STREAM` is defined.
- `clk`  in  1  single clock; all state is on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  arbitration enable; gates only the start of new packets.
- `in`  `axis_if.s` array  [CHANNEL_NUMBER]  source streams.
- `out`  `axis_if.m`  1  merged sink stream.
- `grant_valid`  out  1  high while a packet is locked to a source.
- `grant_idx`  out  CHANNEL_NUMBER_WIDTH  index of the locked source.

## Operation
- FSM states:
  - IDLE: no grant; every `in[i].TREADY` is 0.
  - LOCKED: `in[grant_idx]` is connected to the skid buffer.
- IDLE → LOCKED: taken when `en`=1 and any `in[i].TVALID`=1.
  - Winner: the first requesting index at or after `rr_ptr`, searching upward and wrapping modulo CHANNEL_NUMBER.
  - On the transition, register `grant_idx` = winner and set `grant_valid`=1.
- LOCKED → IDLE: taken on the accept (TVALID&&TREADY) of a beat with TLAST=1.
  - Same edge: `rr_ptr` ← (grant_idx+1) mod CHANNEL_NUMBER; `grant_valid` ← 0.
- Under `USE_LIGHT_STREAM`, every beat is treated as TLAST=1, so arbitration is per beat.
- `en` deassertion never truncates a locked packet; it only blocks IDLE → LOCKED.
- Source ready:
  - `in[grant_idx].TREADY` = (state==LOCKED) && (skid buffer holds ≤1 entry).
  - All other sources see TREADY=0.
- Skid buffer: 2 entries holding the full payload (TDATA, TSTRB, TKEEP, TLAST, TID, TDEST, TUSER).
  - `out.TVALID` = buffer non-empty; the sink sees the head entry.
  - Push occurs on a source accept; pop occurs on `out.TVALID && out.TREADY`.
  - Push and pop in the same cycle leave the occupancy unchanged.
  - Ordering is strictly FIFO.
- Payload is passed through unmodified. `out` payload is don't-care while `out.TVALID`=0, except that it is zero after reset.
- Boundary conditions:
  - Buffer full (2 entries): source TREADY is 0 and the source stalls.
  - Simultaneous requests: resolved only by `rr_ptr`.
  - A single requester wins regardless of `rr_ptr`.
  - `rr_ptr` wraps from CHANNEL_NUMBER-1 to 0.
  - TVALID arriving at a non-granted source during LOCKED is ignored until the next IDLE cycle.
  - Sink backpressure never drops beats.

## Timing
- Reset values: `out.TVALID`=0, `out` payload=0, all `in[i].TREADY`=0, `grant_valid`=0, `grant_idx`=0, `rr_ptr`=0, state=IDLE, buffer empty.
- Reset mid-packet: state returns to IDLE immediately and asynchronously, and the buffer is flushed, so `out.TVALID` falls without a handshake. The partial packet is lost; this is accepted under reset.
- Arbitration latency: source TVALID seen in IDLE at edge N → LOCKED and TREADY=1 during cycle N+1 → first beat accepted at edge N+1 if buffer space is available.
- Data latency: a beat accepted at edge K is on `out` with TVALID=1 from edge K (registered).
- Throughput: 1 beat/cycle within a packet while `out.TREADY`=1. There is exactly one IDLE bubble cycle between consecutive packets.
- All outputs are registered except `in[i].TREADY`, which is decoded from registered state and occupancy only. There is no combinational path from `out.TREADY` to `in[i].TREADY`.

## Test plan
- Single source: `in[2]` sends a 4-beat packet 0xA0..0xA3 with TLAST on the last beat, `out.TREADY`=1 → `out` carries 0xA0..0xA3 on consecutive cycles with TLAST on 0xA3; `grant_idx`=2; `in[0,1,3,4].TREADY` stay 0.
- Round-robin: all 5 sources continuously send 2-beat packets → grant order 0,1,2,3,4,0, with one bubble cycle between packets and no interleaving.
- Backpressure: `out.TREADY` toggles 1010… during an 8-beat packet → all 8 beats arrive in order; source TREADY drops only when the buffer holds 2 entries; no beat is lost or duplicated.
- `en` gating: `en`=0 with `in[1]` valid → no grant. Drop `en` mid-packet → the current packet completes through TLAST, then no new grant until `en`=1.
- Wrap and pointer: `rr_ptr`=4, requests on 0 and 3 → 0 wins; the next arbitration with 0 and 3 still requesting → 3 wins.
- Reset mid-packet: assert `rst` after beat 2 of 5 → `out.TVALID`=0 and `grant_valid`=0 immediately. After release, a fresh packet from `in[3]` is delivered intact.
